// File: rtl/memwr_lane_arbiter.sv
// memwr_lane_arbiter
//   Shares the single write port of a lane-partitioned memory between two
//   producers. After reset a sweep clears every word. The block then grants
//   writes round-robin and serves one registered read port.
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   reqN_valid/ready/addr/data/mask  producer N write channel (N = 0,1);
//                                    mask bit i enables data[i*LW +: LW]
//   rd_addr / rd_data                read port, 1-cycle latency, read-before-write
//   wr_grant                         one-hot producer completing a transfer now
//   init_done                        clear sweep finished
module memwr_lane_arbiter #(
   parameter  int WIDTH  = 4,
   parameter  int DEPTH  = 2,
   parameter  int LANES  = 2,
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int LW     = WIDTH / LANES
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [WIDTH-1:0]  req0_data,
   input  logic [LANES-1:0]  req0_mask,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [WIDTH-1:0]  req1_data,
   input  logic [LANES-1:0]  req1_mask,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data,
   output logic [1:0]        wr_grant,
   output logic              init_done
);

   typedef enum logic {INIT, RUN} state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [WIDTH-1:0]  data;
      logic [LANES-1:0]  mask;
   } wreq_t;

   localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t                       state;
   logic [ADDR_W-1:0]            init_cnt;
   logic                         prio1;      // 1: req1 wins the next tie
   logic                         gnt0, gnt1;
   logic                         xfer0, xfer1;
   wreq_t                        wsel;
   wreq_t                        wport;
   logic                         wr_ok;
   logic                         rd_ok;
   logic [LANES-1:0]             we;
   logic [LANES-1:0][LW-1:0]     rword;

   // Grant goes only to a valid producer; a tie goes to whoever was not
   // served by the last transfer.
   assign gnt0 = req0_valid && (!req1_valid || !prio1);
   assign gnt1 = req1_valid && (!req0_valid ||  prio1);

   // Readies drop with the asynchronous reset because state returns to INIT.
   assign req0_ready = (state == RUN) && gnt0;
   assign req1_ready = (state == RUN) && gnt1;
   assign xfer0      = req0_valid && req0_ready;
   assign xfer1      = req1_valid && req1_ready;
   assign wr_grant   = {xfer1, xfer0};

   assign wsel  = gnt1 ? wreq_t'{req1_addr, req1_data, req1_mask}
                       : wreq_t'{req0_addr, req0_data, req0_mask};
   assign wr_ok = ({1'b0, wsel.addr} < DEPTH_W);
   assign rd_ok = ({1'b0, rd_addr}   < DEPTH_W);

   // Single physical write port: the sweep owns it during INIT. An
   // out-of-range address still handshakes but enables no lane.
   always_comb begin
      wport = wsel;
      we    = '0;
      if (state == INIT) begin
         wport = wreq_t'{init_cnt, {WIDTH{1'b0}}, {LANES{1'b1}}};
         we    = '1;
      end else if ((xfer0 || xfer1) && wr_ok) begin
         we    = wsel.mask;
      end
   end

   // Per-lane storage, no reset; the sweep provides the cleared state.
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [LW-1:0] mem [DEPTH];

      always_ff @(posedge clk) begin
         if (we[l]) mem[wport.addr] <= wport.data[l*LW +: LW];
      end

      assign rword[l] = mem[rd_addr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= INIT;
         init_cnt  <= '0;
         init_done <= 1'b0;
         prio1     <= 1'b0;
         rd_data   <= '0;
      end else begin
         case (state)
            INIT: begin
               rd_data <= '0;
               if (init_cnt == LAST_ADDR) begin
                  state     <= RUN;
                  init_done <= 1'b1;
               end else begin
                  init_cnt  <= init_cnt + 1'b1;
               end
            end
            RUN: begin
               // Non-blocking read of the array gives read-before-write.
               rd_data <= rd_ok ? rword : '0;
               if (xfer0 || xfer1) prio1 <= xfer0;
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_memwr_lane_arbiter.sv
module tb_memwr_lane_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0_valid, req0_ready, req1_valid, req1_ready;
   logic [0:0] req0_addr, req1_addr, rd_addr;
   logic [3:0] req0_data, req1_data, rd_data;
   logic [1:0] req0_mask, req1_mask, wr_grant;
   logic       init_done;

   int         n_vec = 0;
   int         n_err = 0;
   logic [3:0] model [2];
   logic [3:0] sb [$];

   always #5 clk = ~clk;

   memwr_lane_arbiter #(.WIDTH(4), .DEPTH(2), .LANES(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
      .req0_data(req0_data), .req0_mask(req0_mask),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
      .req1_data(req1_data), .req1_mask(req1_mask),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_grant(wr_grant), .init_done(init_done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic lane_wr(input logic [0:0] a, input logic [3:0] d, input logic [1:0] m);
      for (int l = 0; l < 2; l++)
         if (m[l]) model[a][l*2 +: 2] = d[l*2 +: 2];
   endtask

   // One RUN cycle: drive, check handshake, push expected read, update model,
   // then pop and compare the registered read after the edge.
   task automatic cyc(input logic v0, input logic [0:0] a0, input logic [3:0] d0,
                      input logic [1:0] m0, input logic v1, input logic [0:0] a1,
                      input logic [3:0] d1, input logic [1:0] m1,
                      input logic [0:0] ra, input logic [1:0] eg);
      @(negedge clk);
      req0_valid = v0; req0_addr = a0; req0_data = d0; req0_mask = m0;
      req1_valid = v1; req1_addr = a1; req1_data = d1; req1_mask = m1;
      rd_addr = ra;
      #1;
      chk("wr_grant", wr_grant, eg);
      if (v0) chk("req0_ready", req0_ready, eg[0]);
      if (v1) chk("req1_ready", req1_ready, eg[1]);
      sb.push_back(model[ra]);
      if (eg[0]) lane_wr(a0, d0, m0);
      if (eg[1]) lane_wr(a1, d1, m1);
      @(posedge clk); #1;
      chk("rd_data", rd_data, sb.pop_front());
   endtask

   task automatic idle(input logic [0:0] ra);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, ra, 2'b00);
   endtask

   task automatic sweep_checks();
      @(posedge clk); #1;
      chk("init_done_c1", init_done, 1'b0);
      chk("rd_init_c1", rd_data, 4'h0);
      @(posedge clk); #1;
      chk("init_done_c2", init_done, 1'b1);
      model[0] = 4'h0; model[1] = 4'h0;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b1;
      req0_valid = 0; req0_addr = 0; req0_data = 0; req0_mask = 0;
      req1_valid = 0; req1_addr = 0; req1_data = 0; req1_mask = 0;
      rd_addr = 0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_rd_data", rd_data, 4'h0);
      chk("rst_init_done", init_done, 1'b0);
      chk("rst_grant", wr_grant, 2'b00);
      req0_valid = 1; req1_valid = 1;
      #1;
      chk("rst_readies", {req1_ready, req0_ready}, 2'b00);
      req0_valid = 0; req1_valid = 0;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      sweep_checks();

      // cleared memory
      idle(0);
      idle(1);

      // back-to-back contention: 01, 10, 01, then lone req1
      cyc(1, 0, 4'h1, 2'b11, 1, 1, 4'h2, 2'b11, 0, 2'b01);
      cyc(1, 1, 4'h3, 2'b11, 1, 1, 4'h2, 2'b11, 1, 2'b10);
      cyc(1, 1, 4'h3, 2'b11, 1, 0, 4'h4, 2'b11, 1, 2'b01);
      cyc(0, 0, 4'h0, 2'b00, 1, 0, 4'h4, 2'b11, 0, 2'b10);
      idle(0);
      idle(1);

      // single write, readback one cycle later
      cyc(1, 1, 4'hA, 2'b11, 0, 0, 0, 0, 1, 2'b01);
      idle(1);

      // lane merge on addr 0, then mask-00 write
      cyc(1, 0, 4'hA, 2'b01, 0, 0, 0, 0, 0, 2'b01);
      cyc(0, 0, 0, 0, 1, 0, 4'h5, 2'b10, 0, 2'b10);
      idle(0);
      chk("merge_word", rd_data, 4'h6);
      cyc(1, 0, 4'hF, 2'b00, 0, 0, 0, 0, 0, 2'b01);
      idle(0);
      chk("mask00_word", rd_data, 4'h6);
      // pointer advanced by the mask-00 transfer: req1 wins the tie
      cyc(1, 1, 4'h9, 2'b11, 1, 1, 4'hA, 2'b11, 1, 2'b10);
      idle(1);

      // read-before-write on the same address
      cyc(0, 0, 0, 0, 1, 1, 4'h3, 2'b11, 1, 2'b10);
      idle(1);
      chk("rbw_new_word", rd_data, 4'h3);

      // reset mid-transfer
      @(negedge clk);
      req0_valid = 1; req0_addr = 0; req0_data = 4'hF; req0_mask = 2'b11;
      #1;
      chk("pre_rst_ready", req0_ready, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rst_ready_drop", req0_ready, 1'b0);
      chk("rst_grant_drop", wr_grant, 2'b00);
      chk("rst_init_drop", init_done, 1'b0);
      chk("rst_rd_clear", rd_data, 4'h0);
      @(negedge clk);
      req0_valid = 0;
      rst_n = 1'b1;
      sweep_checks();
      idle(0);
      idle(1);
      cyc(1, 0, 4'h7, 2'b11, 1, 1, 4'h8, 2'b11, 0, 2'b01);
      idle(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
